// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, the fetch FSM state type and the
// "no register" encoding, plus a byte-insert helper for valC assembly.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_NONE   = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BYTE0  = 3'd1,
        S_REGS   = 3'd2,
        S_VALC   = 3'd3,
        S_DONE   = 3'd4,
        S_HALTED = 3'd5
    } fetch_state_t;

    // valC is little-endian: constant byte k lands in bits [8k+7:8k].
    function automatic logic [63:0] put_byte(input logic [63:0] word,
                                             input logic [2:0]  k,
                                             input logic [7:0]  b);
        logic [63:0] r;
        r = word;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/y86_ins_len.sv
// Combinational Y86-64 format decoder: length, regid/valC presence and
// ifun legality for an icode/ifun pair. Unknown icodes report ifun_valid=0.
module y86_ins_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic [3:0] len,
    output logic       need_regids,
    output logic       need_valc,
    output logic       ifun_valid
);

    always_comb begin
        len         = 4'd1;
        need_regids = 1'b0;
        need_valc   = 1'b0;
        ifun_valid  = (ifun == 4'd0);
        case (icode)
            I_HALT, I_NOP, I_RET: begin
            end
            I_RRMOVQ: begin
                len         = 4'd2;
                need_regids = 1'b1;
                ifun_valid  = (ifun <= 4'd6);
            end
            I_OPQ: begin
                len         = 4'd2;
                need_regids = 1'b1;
                ifun_valid  = (ifun <= 4'd3);
            end
            I_PUSHQ, I_POPQ: begin
                len         = 4'd2;
                need_regids = 1'b1;
            end
            I_JXX: begin
                len        = 4'd9;
                need_valc  = 1'b1;
                ifun_valid = (ifun <= 4'd6);
            end
            I_CALL: begin
                len       = 4'd9;
                need_valc = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len         = 4'd10;
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            default: begin
                ifun_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/y86_fetch_unit.sv
// Sequential Y86-64 fetch stage: byte-serial instruction read, field split,
// valid/ready hand-off. Optional counters under `Y86_FETCH_PERF_EN`.
//
// Handshake: the parsed instruction is transferred on a cycle where
// ins_valid && ins_ready; while ins_valid is high and ins_ready is low every
// output holds its value, and ins_valid never drops without a transfer.
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_new,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_err,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [3:0]        Ins_Code,
    output logic [3:0]        Ins_fun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       val_C,
    output logic [ADDR_W-1:0] val_P,
    output logic              need_regids,
    output logic              need_Val_C,
    output logic              instruction_invalid_check,
    output logic              mem_invalid_check,
    output logic              halt,
`ifdef Y86_FETCH_PERF_EN
    output logic [31:0]       perf_ins_count,
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic [2:0]        dbg_state
);

    fetch_state_t      state_q, state_d;
    logic              issue_q, issue_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] val_p_q, val_p_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [3:0]        icode_q, icode_d, ifun_q, ifun_d;
    logic [3:0]        ra_q, ra_d, rb_q, rb_d;
    logic [63:0]       val_c_q, val_c_d;
    logic              need_regids_q, need_regids_d;
    logic              need_valc_q, need_valc_d;
    logic              ins_inv_q, ins_inv_d;
    logic              mem_inv_q, mem_inv_d;
    logic              halt_q, halt_d;
    logic              ins_valid_q, ins_valid_d;

    logic              in_fetch, rsp, more;
    logic [3:0]        dec_len;
    logic              dec_nr, dec_nv, dec_ok;

    y86_ins_len u_ins_len (
        .icode       (mem_rdata[7:4]),
        .ifun        (mem_rdata[3:0]),
        .len         (dec_len),
        .need_regids (dec_nr),
        .need_valc   (dec_nv),
        .ifun_valid  (dec_ok)
    );

    // A response can only belong to a request already on the bus, so a strobe
    // in the issue cycle itself (or outside a fetch) is stale and dropped.
    assign in_fetch = (state_q == S_BYTE0) || (state_q == S_REGS) || (state_q == S_VALC);
    assign rsp      = mem_rvalid && !issue_q && in_fetch;

    always_comb begin
        state_d       = state_q;
        issue_d       = issue_q;
        addr_d        = addr_q;
        pc_d          = pc_q;
        val_p_d       = val_p_q;
        byte_cnt_d    = byte_cnt_q;
        icode_d       = icode_q;
        ifun_d        = ifun_q;
        ra_d          = ra_q;
        rb_d          = rb_q;
        val_c_d       = val_c_q;
        need_regids_d = need_regids_q;
        need_valc_d   = need_valc_q;
        ins_inv_d     = ins_inv_q;
        mem_inv_d     = mem_inv_q;
        halt_d        = halt_q;
        ins_valid_d   = ins_valid_q;
        more          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pc_load) begin
                    state_d       = S_BYTE0;
                    issue_d       = 1'b1;
                    addr_d        = pc_new;
                    pc_d          = pc_new;
                    val_p_d       = '0;
                    byte_cnt_d    = 3'd0;
                    icode_d       = 4'h0;
                    ifun_d        = 4'h0;
                    ra_d          = F_NONE;
                    rb_d          = F_NONE;
                    val_c_d       = 64'd0;
                    need_regids_d = 1'b0;
                    need_valc_d   = 1'b0;
                    ins_inv_d     = 1'b0;
                    mem_inv_d     = 1'b0;
                    halt_d        = 1'b0;
                end
            end
            S_BYTE0, S_REGS, S_VALC: begin
                issue_d = 1'b0;
                if (rsp && mem_err) begin
                    state_d       = S_DONE;
                    ins_valid_d   = 1'b1;
                    icode_d       = 4'h0;
                    ifun_d        = 4'h0;
                    ra_d          = 4'h0;
                    rb_d          = 4'h0;
                    val_c_d       = 64'd0;
                    val_p_d       = '0;
                    need_regids_d = 1'b0;
                    need_valc_d   = 1'b0;
                    ins_inv_d     = 1'b0;
                    mem_inv_d     = 1'b1;
                    halt_d        = 1'b1;
                end else if (rsp) begin
                    addr_d = addr_q + ADDR_W'(1);
                    case (state_q)
                        S_BYTE0: begin
                            icode_d = mem_rdata[7:4];
                            ifun_d  = mem_rdata[3:0];
                            if (!dec_ok) begin
                                state_d     = S_DONE;
                                ins_valid_d = 1'b1;
                                ins_inv_d   = 1'b1;
                                halt_d      = 1'b1;
                                val_p_d     = pc_q + ADDR_W'(1);
                            end else begin
                                need_regids_d = dec_nr;
                                need_valc_d   = dec_nv;
                                val_p_d       = pc_q + ADDR_W'(dec_len);
                                halt_d        = (mem_rdata[7:4] == I_HALT);
                                more          = dec_nr || dec_nv;
                                if (dec_nr) begin
                                    state_d = S_REGS;
                                end else if (dec_nv) begin
                                    state_d = S_VALC;
                                end else begin
                                    state_d     = S_DONE;
                                    ins_valid_d = 1'b1;
                                end
                            end
                        end
                        S_REGS: begin
                            ra_d = mem_rdata[7:4];
                            rb_d = mem_rdata[3:0];
                            more = need_valc_q;
                            if (need_valc_q) begin
                                state_d = S_VALC;
                            end else begin
                                state_d     = S_DONE;
                                ins_valid_d = 1'b1;
                            end
                        end
                        default: begin
                            val_c_d    = put_byte(val_c_q, byte_cnt_q, mem_rdata);
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            more       = (byte_cnt_q != 3'd7);
                            if (byte_cnt_q == 3'd7) begin
                                state_d     = S_DONE;
                                ins_valid_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                if (ins_ready) begin
                    ins_valid_d = 1'b0;
                    state_d     = halt_q ? S_HALTED : S_IDLE;
                end
            end
            S_HALTED: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            issue_q       <= 1'b0;
            addr_q        <= '0;
            pc_q          <= '0;
            val_p_q       <= '0;
            byte_cnt_q    <= 3'd0;
            icode_q       <= 4'h0;
            ifun_q        <= 4'h0;
            ra_q          <= F_NONE;
            rb_q          <= F_NONE;
            val_c_q       <= 64'd0;
            need_regids_q <= 1'b0;
            need_valc_q   <= 1'b0;
            ins_inv_q     <= 1'b0;
            mem_inv_q     <= 1'b0;
            halt_q        <= 1'b0;
            ins_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_q       <= issue_d;
            addr_q        <= addr_d;
            pc_q          <= pc_d;
            val_p_q       <= val_p_d;
            byte_cnt_q    <= byte_cnt_d;
            icode_q       <= icode_d;
            ifun_q        <= ifun_d;
            ra_q          <= ra_d;
            rb_q          <= rb_d;
            val_c_q       <= val_c_d;
            need_regids_q <= need_regids_d;
            need_valc_q   <= need_valc_d;
            ins_inv_q     <= ins_inv_d;
            mem_inv_q     <= mem_inv_d;
            halt_q        <= halt_d;
            ins_valid_q   <= ins_valid_d;
        end
    end

    // The follow-on request overlaps the response that makes it necessary,
    // which is what lets a 1-cycle memory stream one byte per cycle.
    assign mem_req  = issue_q || (rsp && !mem_err && more);
    assign mem_addr = !mem_req ? '0 : (issue_q ? addr_q : addr_q + ADDR_W'(1));

    assign ins_valid                 = ins_valid_q;
    assign Ins_Code                  = icode_q;
    assign Ins_fun                   = ifun_q;
    assign rA                        = ra_q;
    assign rB                        = rb_q;
    assign val_C                     = val_c_q;
    assign val_P                     = val_p_q;
    assign need_regids               = need_regids_q;
    assign need_Val_C                = need_valc_q;
    assign instruction_invalid_check = ins_inv_q;
    assign mem_invalid_check         = mem_inv_q;
    assign halt                      = halt_q;
    assign dbg_state                 = state_q;

`ifdef Y86_FETCH_PERF_EN
    logic [31:0] perf_ins_q, perf_ins_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ins_d   = perf_ins_q;
        perf_stall_d = perf_stall_q;
        if (ins_valid_q && ins_ready && (perf_ins_q != 32'hFFFF_FFFF)) begin
            perf_ins_d = perf_ins_q + 32'd1;
        end
        if (ins_valid_q && !ins_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ins_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_ins_q   <= perf_ins_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ins_count    = perf_ins_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed bench for y86_fetch_unit: table of single-instruction fetches
// against a 1-cycle byte memory, plus error, backpressure and reset sequences.
module tb_y86_fetch_unit;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst, pc_load, ins_ready;
    logic [63:0] pc_new;
    logic        mem_req, mem_rvalid, mem_err;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        ins_valid;
    logic [3:0]  Ins_Code, Ins_fun, rA, rB;
    logic [63:0] val_C, val_P;
    logic        need_regids, need_Val_C;
    logic        instruction_invalid_check, mem_invalid_check, halt;
    logic [2:0]  dbg_state;
`ifdef Y86_FETCH_PERF_EN
    logic [31:0] perf_ins_count, perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    y86_fetch_unit #(.ADDR_W(64)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .pc_load                   (pc_load),
        .pc_new                    (pc_new),
        .mem_req                   (mem_req),
        .mem_addr                  (mem_addr),
        .mem_rvalid                (mem_rvalid),
        .mem_rdata                 (mem_rdata),
        .mem_err                   (mem_err),
        .ins_valid                 (ins_valid),
        .ins_ready                 (ins_ready),
        .Ins_Code                  (Ins_Code),
        .Ins_fun                   (Ins_fun),
        .rA                        (rA),
        .rB                        (rB),
        .val_C                     (val_C),
        .val_P                     (val_P),
        .need_regids               (need_regids),
        .need_Val_C                (need_Val_C),
        .instruction_invalid_check (instruction_invalid_check),
        .mem_invalid_check         (mem_invalid_check),
        .halt                      (halt),
`ifdef Y86_FETCH_PERF_EN
        .perf_ins_count            (perf_ins_count),
        .perf_stall_cycles         (perf_stall_cycles),
`endif
        .dbg_state                 (dbg_state)
    );

    // 1-cycle byte memory with an optional error address and a manual
    // response injector for stale-strobe tests.
    logic [7:0]  mem [0:511];
    logic        m_rvalid = 1'b0;
    logic        m_err    = 1'b0;
    logic [7:0]  m_rdata  = 8'h00;
    logic        err_en   = 1'b0;
    logic [63:0] err_addr = 64'd0;
    logic        f_rvalid = 1'b0;
    logic [7:0]  f_rdata  = 8'h00;
    int          req_cnt  = 0;

    always @(posedge clk) begin
        m_rvalid <= mem_req;
        m_rdata  <= mem[mem_addr[8:0]];
        m_err    <= mem_req && err_en && (mem_addr == err_addr);
    end

    always @(posedge clk) begin
        if (mem_req === 1'b1) req_cnt++;
    end

    assign mem_rvalid = m_rvalid | f_rvalid;
    assign mem_rdata  = f_rvalid ? f_rdata : m_rdata;
    assign mem_err    = m_rvalid & m_err;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        int          nbytes;
        int          lat;
        logic [3:0]  code, fun, ra, rb;
        logic [63:0] valc, valp;
        logic        nr, nv, inv, hlt;
    } vec_t;

    vec_t vecs [12];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic [63:0] pc, input logic [79:0] b, input int n,
                                input int lat, input logic [3:0] c, input logic [3:0] f,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input logic [63:0] vp,
                                input logic nr, input logic nv, input logic inv,
                                input logic hl);
        vec_t v;
        v.pc = pc; v.bytes = b; v.nbytes = n; v.lat = lat;
        v.code = c; v.fun = f; v.ra = ra; v.rb = rb;
        v.valc = vc; v.valp = vp; v.nr = nr; v.nv = nv; v.inv = inv; v.hlt = hl;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic load_vec(input vec_t v);
        logic [63:0] a;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        for (int k = 0; k < v.nbytes; k++) begin
            a = v.pc + 64'(k);
            mem[a[8:0]] = v.bytes[79 - 8 * k -: 8];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pc_load = 1'b0; ins_ready = 1'b0; pc_new = 64'd0;
        err_en = 1'b0; f_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns the cycle (pc_load cycle = 0) in which ins_valid is first seen.
    task automatic run_fetch(input logic [63:0] pc, output int cyc);
        logic got;
        @(negedge clk);
        pc_new = pc; pc_load = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            pc_load = 1'b0;
            got = (ins_valid === 1'b1);
        end
        if (!got) check("fetch_timeout", 64'(ins_valid), 64'd1);
    endtask

    task automatic check_fields(input string t, input vec_t v);
        check({t, ".code"}, 64'(Ins_Code), 64'(v.code));
        check({t, ".fun"},  64'(Ins_fun),  64'(v.fun));
        check({t, ".rA"},   64'(rA),       64'(v.ra));
        check({t, ".rB"},   64'(rB),       64'(v.rb));
        check({t, ".valC"}, val_C,         v.valc);
        check({t, ".valP"}, val_P,         v.valp);
        check({t, ".need_regids"}, 64'(need_regids), 64'(v.nr));
        check({t, ".need_valC"},   64'(need_Val_C),  64'(v.nv));
        check({t, ".ins_inv"},     64'(instruction_invalid_check), 64'(v.inv));
        check({t, ".mem_inv"},     64'(mem_invalid_check), 64'd0);
        check({t, ".halt"},        64'(halt), 64'(v.hlt));
    endtask

    task automatic check_reset_outputs(input string t);
        check({t, ".valid"},   64'(ins_valid), 64'd0);
        check({t, ".mem_req"}, 64'(mem_req),   64'd0);
        check({t, ".addr"},    mem_addr,       64'd0);
        check({t, ".code"},    64'(Ins_Code),  64'd0);
        check({t, ".fun"},     64'(Ins_fun),   64'd0);
        check({t, ".rA"},      64'(rA),        64'(F_NONE));
        check({t, ".rB"},      64'(rB),        64'(F_NONE));
        check({t, ".valC"},    val_C,          64'd0);
        check({t, ".valP"},    val_P,          64'd0);
        check({t, ".flags"},   64'({need_regids, need_Val_C, instruction_invalid_check,
                                    mem_invalid_check, halt}), 64'd0);
        check({t, ".state"},   64'(dbg_state), 64'(S_IDLE));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int    cyc;
        int    r0;
        string t;
        vec_t  v;

        rst = 1'b1; pc_load = 1'b0; ins_ready = 1'b0; pc_new = 64'd0;

        vecs[0]  = mk(64'h100, 80'h30F20A00000000000000, 10, 12, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'h10A, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(64'h000, 80'h60010000000000000000,  2,  4, 4'h6, 4'h0, 4'h0, 4'h1, 64'd0, 64'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(64'h040, 80'h71EFBEADDE0000000000,  9, 11, 4'h7, 4'h1, 4'hF, 4'hF, 64'hDEADBEEF, 64'h49, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(64'h010, 80'h10000000000000000000,  1,  3, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(64'h020, 80'h00000000000000000000,  1,  3, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h21, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[5]  = mk(64'h080, 80'hC0000000000000000000,  1,  3, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[6]  = mk(64'h090, 80'h64000000000000000000,  1,  3, 4'h6, 4'h4, 4'hF, 4'hF, 64'd0, 64'h91, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[7]  = mk(64'h1F0, 80'h80000100000000000000,  9, 11, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h1F9, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(64'hFFFF_FFFF_FFFF_FFFA, 80'h50130800000000000000, 10, 12, 4'h5, 4'h0, 4'h1, 4'h3, 64'd8, 64'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(64'h030, 80'hA04F0000000000000000,  2,  4, 4'hA, 4'h0, 4'h4, 4'hF, 64'd0, 64'h32, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(64'h0A0, 80'h27000000000000000000,  1,  3, 4'h2, 4'h7, 4'hF, 4'hF, 64'd0, 64'hA1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[11] = mk(64'h0B0, 80'h90000000000000000000,  1,  3, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'hB1, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset();
        check_reset_outputs("reset");

        // Table: fetch, compare, accept, then probe whether pc_load still works.
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            t = $sformatf("vec%0d", i);
            do_reset();
            load_vec(v);
            run_fetch(v.pc, cyc);
            check({t, ".latency"}, 64'(cyc), 64'(v.lat));
            check_fields(t, v);
            ins_ready = 1'b1;
            @(negedge clk);
            ins_ready = 1'b0;
            check({t, ".valid_after_accept"}, 64'(ins_valid), 64'd0);
            check({t, ".state_after_accept"}, 64'(dbg_state), v.hlt ? 64'(S_HALTED) : 64'(S_IDLE));
            r0 = req_cnt;
            pc_load = 1'b1; pc_new = v.pc;
            @(negedge clk);
            pc_load = 1'b0;
            repeat (2) @(negedge clk);
            check({t, ".post_pc_load_req"}, 64'(req_cnt != r0), v.hlt ? 64'd0 : 64'd1);
        end

        // Memory error on byte 3 of rmmovq: fields cleared, no further requests.
        do_reset();
        v = mk(64'h1C0, 80'h40120800000000000000, 10, 6, 4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_vec(v);
        err_addr = 64'h1C3; err_en = 1'b1;
        run_fetch(v.pc, cyc);
        check("memerr.latency", 64'(cyc), 64'd6);
        check("memerr.mem_inv", 64'(mem_invalid_check), 64'd1);
        check("memerr.halt",    64'(halt), 64'd1);
        check("memerr.ins_inv", 64'(instruction_invalid_check), 64'd0);
        check("memerr.fields",  64'({Ins_Code, Ins_fun, rA, rB, need_regids, need_Val_C}), 64'd0);
        check("memerr.valC",    val_C, 64'd0);
        check("memerr.valP",    val_P, 64'd0);
        r0 = req_cnt;
        repeat (4) @(negedge clk);
        check("memerr.no_more_req", 64'(req_cnt - r0), 64'd0);
        ins_ready = 1'b1;
        @(negedge clk);
        ins_ready = 1'b0;
        check("memerr.halted", 64'(dbg_state), 64'(S_HALTED));
        r0 = req_cnt;
        pc_load = 1'b1; pc_new = 64'h0;
        @(negedge clk);
        pc_load = 1'b0;
        repeat (2) @(negedge clk);
        check("memerr.halted_ignores_pc_load", 64'(req_cnt - r0), 64'd0);

        // Backpressure: outputs frozen; a pc_load in the accept cycle is dropped.
        do_reset();
        load_vec(vecs[0]);
        run_fetch(vecs[0].pc, cyc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            t = $sformatf("bp%0d", k);
            check({t, ".valid"}, 64'(ins_valid), 64'd1);
            check_fields(t, vecs[0]);
        end
        r0 = req_cnt;
        ins_ready = 1'b1; pc_load = 1'b1; pc_new = 64'h0;
        @(negedge clk);
        ins_ready = 1'b0; pc_load = 1'b0;
        check("bp.valid_after_accept", 64'(ins_valid), 64'd0);
        check("bp.state_after_accept", 64'(dbg_state), 64'(S_IDLE));
        repeat (2) @(negedge clk);
        check("bp.accept_beats_pc_load", 64'(req_cnt - r0), 64'd0);

        // Reset in the middle of VALC, then a late response while idle.
        do_reset();
        load_vec(vecs[0]);
        @(negedge clk);
        pc_new = vecs[0].pc; pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst.in_valc", 64'(dbg_state), 64'(S_VALC));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk);
        f_rvalid = 1'b1; f_rdata = 8'h30;
        @(negedge clk);
        check("late_rsp.no_req", 64'(mem_req), 64'd0);
        f_rvalid = 1'b0;
        @(negedge clk);
        check_reset_outputs("late_rsp");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
